// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Owns the single data-RAM port and shares it between the CPU
//             load/store path and the UART programmer (UPG). BOOT mode serves
//             only UPG; RUN mode round-robins CPU and UPG.
//  Options  : DMEM_ALIGN_CHECK_EN - reject misaligned CPU accesses and flag
//             them on align_err for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter bit START_IN_RUN = 1'b0
) (
    input  logic              clock,
    input  logic              rst_n,
    // CPU load/store path
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    // UART programmer
    input  logic              upg_req,
    input  logic              upg_we,
    input  logic [ADDR_W-1:0] upg_adr_i,
    input  logic [31:0]       upg_dat_i,
    output logic              upg_gnt,
    output logic              upg_rvalid,
    output logic [31:0]       upg_rdata,
    input  logic              upg_start_i,
    input  logic              upg_done_i,
    // RAM macro
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    // status
    output logic              mode,
    output logic              align_err
);

    localparam logic [0:0] BOOT     = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;
    localparam logic       LAST_CPU = 1'b0;
    localparam logic       LAST_UPG = 1'b1;

    logic [0:0]        state;
    logic              last;
    logic              cpu_rvalid_q;
    logic              upg_rvalid_q;
    logic              misaligned;
    logic [ADDR_W-1:0] cpu_word;
    logic              unused_addr_bits;

    assign cpu_word         = cpu_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic align_err_q;
    assign misaligned = |cpu_addr[1:0];
    assign align_err  = align_err_q;

    // Flag a rejected misaligned CPU access for the following cycle.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= cpu_gnt & misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign align_err  = 1'b0;
`endif

    // Grant selection: UPG only in BOOT, round-robin on ties in RUN.
    always_comb begin
        cpu_gnt = 1'b0;
        upg_gnt = 1'b0;
        if (state == RUN) begin
            if (cpu_req && (!upg_req || last == LAST_UPG)) begin
                cpu_gnt = 1'b1;
            end else if (upg_req) begin
                upg_gnt = 1'b1;
            end
        end else begin
            upg_gnt = upg_req;
        end
    end

    // Steer the granted requester onto the RAM port; idle port is all zero.
    always_comb begin
        ram_wen = 1'b0;
        ram_adr = '0;
        ram_din = '0;
        if (cpu_gnt) begin
            ram_wen = cpu_we & ~misaligned;
            ram_adr = cpu_word;
            ram_din = cpu_wdata;
        end else if (upg_gnt) begin
            ram_wen = upg_we;
            ram_adr = upg_adr_i;
            ram_din = upg_dat_i;
        end
    end

    // Mode FSM; a start request overrides a simultaneous done.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state <= START_IN_RUN ? RUN : BOOT;
        end else if (upg_start_i) begin
            state <= BOOT;
        end else if (upg_done_i) begin
            state <= RUN;
        end
    end

    // Round-robin pointer remembers who was granted most recently.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            last <= LAST_UPG;
        end else if (cpu_gnt) begin
            last <= LAST_CPU;
        end else if (upg_gnt) begin
            last <= LAST_UPG;
        end
    end

    // Read-return flags track the one-cycle RAM read latency.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cpu_rvalid_q <= 1'b0;
            upg_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= cpu_gnt & ~cpu_we & ~misaligned;
            upg_rvalid_q <= upg_gnt & ~upg_we;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign upg_rvalid = upg_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? ram_dout : 32'h0;
    assign upg_rdata  = upg_rvalid_q ? ram_dout : 32'h0;
    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign mode       = state;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter: vector table, directed
//             corner sequences and randomized traffic against a reference
//             model of the arbitration rules and memory contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        upg_req, upg_we;
    logic [13:0] upg_adr_i;
    logic [31:0] upg_dat_i;
    logic        upg_gnt, upg_rvalid;
    logic [31:0] upg_rdata;
    logic        upg_start_i, upg_done_i;
    logic        ram_wen;
    logic [13:0] ram_adr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        mode, align_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(14), .START_IN_RUN(1'b0)) dut (
        .clock(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .upg_req(upg_req), .upg_we(upg_we), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
        .upg_gnt(upg_gnt), .upg_rvalid(upg_rvalid), .upg_rdata(upg_rdata),
        .upg_start_i(upg_start_i), .upg_done_i(upg_done_i),
        .ram_wen(ram_wen), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout),
        .mode(mode), .align_err(align_err)
    );

    // Single-port synchronous RAM macro stand-in (read-before-write)
    bit [31:0] ram [0:16383];
    always @(posedge clk) begin
        if (ram_wen) ram[ram_adr] <= ram_din;
        ram_dout <= ram[ram_adr];
    end

    // Reference model state
    bit        m_mode;
    bit        m_last_upg;
    bit        m_cpu_pv, m_upg_pv, m_aerr;
    bit [31:0] m_cpu_pd, m_upg_pd;
    bit [31:0] m_mem [0:16383];

    // Values sampled in the most recent cycle, for directed checks
    logic s_cg, s_ug, s_stall, s_wen, s_mode, s_crv, s_urv, s_aerr;
    logic [31:0] s_crd, s_urd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        upg_req = 0; upg_we = 0; upg_adr_i = 0; upg_dat_i = 0;
        upg_start_i = 0; upg_done_i = 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_last_upg = 1; m_cpu_pv = 0; m_upg_pv = 0; m_aerr = 0;
        m_cpu_pd = 0; m_upg_pd = 0;
    endtask

    // Called at a negedge with inputs applied; checks this cycle, advances
    // the model across the next rising edge, returns at the following negedge.
    task automatic cycle();
        bit          mis, cg, ug, e_wen;
        bit [13:0]   e_adr;
        bit [31:0]   e_din, rd;
        #1;
        mis = ALIGN_EN && (cpu_addr[1:0] != 2'b00);
        cg  = m_mode && cpu_req && (!upg_req || m_last_upg);
        ug  = upg_req && !cg;
        e_wen = 0; e_adr = 0; e_din = 0;
        if (cg) begin
            e_wen = cpu_we && !mis; e_adr = cpu_addr[15:2]; e_din = cpu_wdata;
        end else if (ug) begin
            e_wen = upg_we; e_adr = upg_adr_i; e_din = upg_dat_i;
        end
        s_cg = cpu_gnt; s_ug = upg_gnt; s_stall = cpu_stall; s_wen = ram_wen;
        s_mode = mode; s_crv = cpu_rvalid; s_urv = upg_rvalid; s_aerr = align_err;
        s_crd = cpu_rdata; s_urd = upg_rdata;
        chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, cg});
        chk("upg_gnt", {31'b0, upg_gnt}, {31'b0, ug});
        chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && !cg});
        chk("ram_wen", {31'b0, ram_wen}, {31'b0, e_wen});
        chk("ram_adr", {18'b0, ram_adr}, {18'b0, e_adr});
        chk("ram_din", ram_din, e_din);
        chk("mode", {31'b0, mode}, {31'b0, m_mode});
        chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_cpu_pv});
        chk("cpu_rdata", cpu_rdata, m_cpu_pv ? m_cpu_pd : 32'h0);
        chk("upg_rvalid", {31'b0, upg_rvalid}, {31'b0, m_upg_pv});
        chk("upg_rdata", upg_rdata, m_upg_pv ? m_upg_pd : 32'h0);
        chk("align_err", {31'b0, align_err}, {31'b0, m_aerr});
        @(posedge clk);
        rd = m_mem[e_adr];
        if (e_wen) m_mem[e_adr] = e_din;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_cpu_pv = cg && !cpu_we && !mis;
            m_upg_pv = ug && !upg_we;
            m_cpu_pd = rd;
            m_upg_pd = rd;
            m_aerr   = cg && mis;
            if (cg) m_last_upg = 0;
            else if (ug) m_last_upg = 1;
            if (upg_start_i) m_mode = 0;
            else if (upg_done_i) m_mode = 1;
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit cr, cw, ur, uw, st, dn;
        bit e_cg, e_ug, e_wen, e_stall, e_mode;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1,0,0,0,0,0, 0,0,0,1,0};
        tbl[1]  = '{1,0,0,0,0,0, 0,0,0,1,0};
        tbl[2]  = '{1,0,0,0,0,0, 0,0,0,1,0};
        tbl[3]  = '{1,0,1,1,0,0, 0,1,1,1,0};
        tbl[4]  = '{0,0,0,0,0,1, 0,0,0,0,0};
        tbl[5]  = '{1,0,1,0,0,0, 1,0,0,0,1};
        tbl[6]  = '{1,0,1,0,0,0, 0,1,0,1,1};
        tbl[7]  = '{1,0,1,0,0,0, 1,0,0,0,1};
        tbl[8]  = '{1,1,0,0,0,0, 1,0,1,0,1};
        tbl[9]  = '{0,0,1,0,0,0, 0,1,0,0,1};
        tbl[10] = '{1,0,1,0,1,1, 1,0,0,0,1};
        tbl[11] = '{1,0,1,0,0,0, 0,1,0,1,0};
        tbl[12] = '{0,0,0,0,0,0, 0,0,0,0,0};

        // Reset
        set_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1;

        // Vector table, starting from reset state (BOOT)
        for (int i = 0; i < 13; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = 32'h18;
            cpu_wdata = 32'hC0DE_0000 + i;
            upg_req = tbl[i].ur; upg_we = tbl[i].uw; upg_adr_i = 14'd6;
            upg_dat_i = 32'hA5A5_0000 + i;
            upg_start_i = tbl[i].st; upg_done_i = tbl[i].dn;
            cycle();
            chk($sformatf("tbl%0d_cpu_gnt", i), {31'b0, s_cg}, {31'b0, tbl[i].e_cg});
            chk($sformatf("tbl%0d_upg_gnt", i), {31'b0, s_ug}, {31'b0, tbl[i].e_ug});
            chk($sformatf("tbl%0d_wen", i), {31'b0, s_wen}, {31'b0, tbl[i].e_wen});
            chk($sformatf("tbl%0d_stall", i), {31'b0, s_stall}, {31'b0, tbl[i].e_stall});
            chk($sformatf("tbl%0d_mode", i), {31'b0, s_mode}, {31'b0, tbl[i].e_mode});
        end
        set_idle();

        // BOOT: UPG writes word 5, done pulse, CPU reads byte address 0x14
        upg_req = 1; upg_we = 1; upg_adr_i = 14'd5; upg_dat_i = 32'hDEADBEEF;
        cycle();
        chk("boot_upg_write", {31'b0, s_wen}, 32'd1);
        set_idle(); upg_done_i = 1;
        cycle();
        set_idle(); cpu_req = 1; cpu_addr = 32'h14;
        cycle();
        chk("run_mode_after_done", {31'b0, s_mode}, 32'd1);
        chk("run_cpu_gnt", {31'b0, s_cg}, 32'd1);
        set_idle();
`ifdef DMEM_ALIGN_CHECK_EN
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h15; cpu_wdata = 32'h1;
`endif
        cycle();
        chk("cpu_rvalid_deadbeef", {31'b0, s_crv}, 32'd1);
        chk("cpu_rdata_deadbeef", s_crd, 32'hDEADBEEF);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("misaligned_no_wen", {31'b0, s_wen}, 32'd0);
        set_idle(); cpu_req = 1; cpu_addr = 32'h14;
        cycle();
        chk("align_err_set", {31'b0, s_aerr}, 32'd1);
        set_idle();
        cycle();
        chk("align_err_clear", {31'b0, s_aerr}, 32'd0);
        chk("old_value_kept", s_crd, 32'hDEADBEEF);
`endif
        set_idle();

        // RUN: UPG-only read leaves last=UPG, then 4 cycles of dual reads
        upg_req = 1; upg_adr_i = 14'd5;
        cycle();
        cpu_req = 1; cpu_addr = 32'h18;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("rr%0d_cpu_gnt", i), {31'b0, s_cg}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_wen", i), {31'b0, s_wen}, 32'd0);
        end
        set_idle();

        // start and done together in RUN with a CPU read in the same cycle
        cpu_req = 1; cpu_addr = 32'h14; upg_start_i = 1; upg_done_i = 1;
        cycle();
        chk("sd_cpu_gnt", {31'b0, s_cg}, 32'd1);
        set_idle();
        cycle();
        chk("sd_mode_boot", {31'b0, s_mode}, 32'd0);
        chk("sd_cpu_rvalid", {31'b0, s_crv}, 32'd1);

        // Reset right after a granted read
        upg_done_i = 1;
        cycle();
        set_idle(); cpu_req = 1; cpu_addr = 32'h14;
        cycle();
        set_idle(); rst_n = 0;
        cycle();
        rst_n = 1;
        cycle();
        chk("rst_cpu_rvalid", {31'b0, s_crv}, 32'd0);
        chk("rst_cpu_rdata", s_crd, 32'd0);
        chk("rst_mode", {31'b0, s_mode}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 63) != 0);
            upg_start_i = ($urandom_range(0, 31) == 0);
            upg_done_i  = ($urandom_range(0, 15) == 0);
            cpu_req     = $urandom_range(0, 1) != 0;
            cpu_we      = $urandom_range(0, 2) == 0;
            cpu_addr    = {$urandom_range(0, 7), 2'b00} |
                          (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
            cpu_wdata   = $urandom;
            upg_req     = $urandom_range(0, 1) != 0;
            upg_we      = $urandom_range(0, 2) == 0;
            upg_adr_i   = 14'($urandom_range(0, 7));
            upg_dat_i   = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Owns the single port of the data RAM and shares it between the CPU load/store path and the UART programmer (UPG). A two-state mode FSM decides whether the RAM is in the programming phase, where only UPG is served, or the run phase, where CPU and UPG are round-robin arbitrated. The block sits between the CPU datapath, the UART programmer and the RAM macro. It generates all RAM control signals and returns read data to whichever requester was granted.

## Interface
- `ADDR_W`, 14: RAM word-address width.
- `START_IN_RUN`, 0: 1 = leave reset in RUN, 0 = leave reset in BOOT.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cpu_req`  in  1  CPU access request, held until granted.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address; the word index is `cpu_addr[ADDR_W+1:2]`.
- `cpu_wdata`  in  32  store data.
- `cpu_gnt`  out  1  CPU access accepted this cycle.
- `cpu_rvalid`  out  1  CPU load data valid.
- `cpu_rdata`  out  32  CPU load data.
- `cpu_stall`  out  1  equals `cpu_req & ~cpu_gnt`.
- `upg_req`  in  1  UPG access request.
- `upg_we`  in  1  UPG write enable.
- `upg_adr_i`  in  ADDR_W  UPG word address.
- `upg_dat_i`  in  32  UPG write data.
- `upg_gnt`  out  1  UPG access accepted this cycle.
- `upg_rvalid`  out  1  UPG read data valid.
- `upg_rdata`  out  32  UPG read data.
- `upg_start_i`  in  1  request entry into programming mode.
- `upg_done_i`  in  1  programming finished.
- `ram_wen`  out  1  RAM write enable.
- `ram_adr`  out  ADDR_W  RAM word address.
- `ram_din`  out  32  RAM write data.
- `ram_dout`  in  32  RAM read data; valid one cycle after address.
- `mode`  out  1  0 = BOOT, 1 = RUN.
- `align_err`  out  1  misaligned CPU access was rejected (see Configuration).

## Operation
- FSM states:
  - **BOOT**: `upg_gnt = upg_req`; `cpu_gnt = 0`.
  - **RUN**: both requesters eligible.
- Transitions:
  - BOOT→RUN when `upg_done_i`=1 at an edge.
  - RUN→BOOT when `upg_start_i`=1 at an edge.
  - If `upg_start_i` and `upg_done_i` are both high, start wins: the FSM goes to or stays in BOOT.
- Round-robin in RUN:
  - A 1-bit `last` pointer records the last granted requester.
  - When both request, the requester other than `last` is granted.
  - When only one requests, that one is granted.
  - `last` updates only on a grant.
  - Reset value: `last` = UPG, so the CPU wins the first tie.
- Exactly one of `cpu_gnt`/`upg_gnt` may be high in any cycle.
- Grants are combinational from the requests and the current state.
- Granted access drives `ram_adr`, `ram_din` and `ram_wen` (= granted `we`) in the same cycle.
- With no grant: `ram_wen`=0, `ram_adr`=0, `ram_din`=0.
- Read return:
  - A granted read sets that requester's `*_rvalid` register for exactly the next cycle.
  - `*_rdata` = `ram_dout` while its `rvalid`=1; otherwise 32'h0.
  - Writes never raise `rvalid`.
- Mode change: a read granted in the last cycle of a mode still returns its data in the following cycle.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `mode` = `START_IN_RUN`.
  - `last` = UPG.
  - `cpu_rvalid`, `upg_rvalid`, `align_err` = 0.
  - Grants follow the requests combinationally, so with all requests low every output is 0.
- Mid-transaction reset clears the pending `rvalid`; its data is dropped.
- Latency:
  - grant in cycle N (same cycle as the request);
  - write commits at the edge ending cycle N;
  - read data valid in cycle N+1.
- Throughput: one access per cycle in total. Back-to-back reads from one requester give continuous `rvalid`.
- Mode switch takes effect in the cycle after `upg_start_i`/`upg_done_i` is sampled. Arbitration in the sampling cycle uses the old mode.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A CPU access with `cpu_addr[1:0] != 0` is granted but suppressed: no RAM write, no `cpu_rvalid`.
  - `align_err` is registered high for one cycle after such an access.
- Not defined:
  - `cpu_addr[1:0]` is ignored.
  - `align_err` is tied to 0.

## Test plan
- Reset with `START_IN_RUN`=0, then `cpu_req`=1 for 3 cycles → `mode`=0, `cpu_gnt`=0, `cpu_stall`=1 each cycle.
- In BOOT, UPG writes 32'hDEADBEEF to word 5. Then pulse `upg_done_i`. Then CPU reads `cpu_addr`=32'h14 → `mode`=1 the next cycle; `cpu_rvalid`=1 with `cpu_rdata`=32'hDEADBEEF one cycle after the grant.
- In RUN, both requesters read continuously for 4 cycles → grants alternate CPU, UPG, CPU, UPG; `ram_wen`=0; each `rvalid` follows its grant by 1 cycle.
- `upg_start_i` and `upg_done_i` high in the same cycle while in RUN → `mode`=0 next cycle; a CPU read granted in that cycle still gets `cpu_rvalid`=1.
- With `DMEM_ALIGN_CHECK_EN`, CPU stores 32'h1 to `cpu_addr`=32'h15 → `ram_wen`=0, `align_err`=1 for one cycle; a following read of word 5 returns the old value.
- Assert `rst_n`=0 in the cycle after a granted read → `cpu_rvalid`=0, `cpu_rdata`=0 in the next cycle.
